data_mem: RTL
=============

# data_mem

Data-memory block of the M stage in the five-stage MIPS pipeline. It takes the effective address and store data from the EX/M pipeline register and performs word, halfword and byte stores. It returns the raw aligned word as `ReadDataM` to the M/W pipeline register, and flags misaligned or out-of-range accesses for CP0. Load sign/zero extension is not done here; it happens after the W-stage register, driven by `ext_sh`.

## Interface
- `ADDR_W`, default 10: word-address width; capacity is 2^ADDR_W words (4 KB at default).
- `BASE`, default 32'h0000_0000: byte address of word 0.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset. Sampled on the `clk` rising edge; clears the whole array.
- `MemWriteM`  in  1: store request this cycle.
- `MemReadM`  in  1: load request this cycle; used only for exception checking.
- `st_typeM`  in  2: store width. 00 = sw, 01 = sh, 10 = sb, 11 = reserved (treated as no store).
- `ext_sh_M`  in  3: load type. 000 = lw, 001 = lbu, 010 = lb, 011 = lhu, 100 = lh; other codes are treated as lw.
- `ALU_outM`  in  32: effective byte address.
- `WriteDataM`  in  32: store data, right-justified for sh/sb.
- `ReadDataM`  out  32: word at `ALU_outM[ADDR_W+1:2]`, unshifted.
- `be_M`  out  4: byte enables of the store being committed. Bit 3 = bits 31:24.
- `AdELM`  out  1: load address exception.
- `AdESM`  out  1: store address exception.

## Operation
- **Word index and range.**
  - idx = (`ALU_outM` - `BASE`) >> 2.
  - In range iff `ALU_outM` - `BASE` < 4·2^ADDR_W, computed as an unsigned 32-bit subtraction (below-base addresses wrap large and so fail).
- **Alignment.**
  - sw and lw require `ALU_outM[1:0]` = 00.
  - sh, lh and lhu require `ALU_outM[0]` = 0.
  - sb, lb and lbu have no alignment requirement.
- **Exception flags.**
  - `AdESM` = `MemWriteM` & (misaligned | out of range).
  - `AdELM` = `MemReadM` & (misaligned | out of range).
  - Both flags are combinational. A reserved `st_typeM` value does not raise `AdESM`.
- **Byte enables.** `be_M` is zero unless `MemWriteM` & !`AdESM` & `st_typeM` != 11.
  - sw: 1111.
  - sh: 0011 when `ALU_outM[1]` = 0; 1100 when it is 1.
  - sb: 0001 << `ALU_outM[1:0]`.
- **Write data lane placement.**
  - sh: `WriteDataM[15:0]` is replicated into both halves.
  - sb: `WriteDataM[7:0]` is replicated into all four bytes.
  - `be_M` selects which lanes are written.
- **Store commit.** On a `clk` rising edge with `reset` = 0, each byte k with `be_M[k]` = 1 is written into word idx. Unenabled bytes keep their value.
- **Read port.**
  - Combinational, asynchronous. `ReadDataM` = mem[idx[ADDR_W-1:0]] regardless of `MemReadM`.
  - Out of range: `ReadDataM` = 0.
- **Faulting accesses.** A faulting store never modifies memory. A faulting load still drives `ReadDataM`; CP0 squashes the write-back.

## Timing
- **Reset.** The first rising edge with `reset` = 1 zeroes every word. There is no state other than the array.
  - After that edge, every in-range read returns 0.
  - A store asserted in the same cycle as `reset` is discarded.
  - Reset asserted mid-sequence overrides any pending store in that cycle.
- **Read latency.** 0 cycles: `ReadDataM` settles within the cycle and is captured by the M/W register at the same edge.
- **Store latency.** Data is visible on `ReadDataM` in the cycle after the commit edge.
- **Read during write.** A read of the same word in the same cycle returns the old contents.
- **Back-to-back stores.** Consecutive stores to the same word merge byte-wise in program order.
- **Outputs during reset.**
  - `be_M` and the exception flags follow their combinational definitions.
  - `ReadDataM` shows pre-reset contents until the reset edge, then 0.
- **Stalls.** The block has no stall input. The upstream hazard unit holds `MemWriteM` low, or inserts a bubble, when M must not commit.

## Test plan
- **Reset clear.** Write 32'hDEADBEEF to 0x10, assert `reset` one cycle, then read 0x10 -> `ReadDataM` = 0.
- **Word then byte store.**
  - sw 32'h11223344 @0x20, then sb 32'hAA @0x22 -> `be_M` = 0100, next read = 32'h11AA3344.
  - sh 32'hBEEF @0x22 -> `be_M` = 1100, next read = 32'hBEEF3344.
- **Misalignment.**
  - sw @0x21 -> `AdESM` = 1, `be_M` = 0000, word at 0x20 unchanged.
  - lh @0x23 -> `AdELM` = 1.
  - lb @0x23 -> no flag.
- **Range.**
  - sw at `BASE` + 4·2^ADDR_W -> `AdESM` = 1, `ReadDataM` = 0.
  - sw at `BASE` + 4·2^ADDR_W - 4 -> commits and reads back.
- **Read during write.** Word 0x30 = 32'h1. Store 32'h2 @0x30 while reading 0x30 -> same-cycle `ReadDataM` = 32'h1, next cycle 32'h2.
- **Reset with store.** `reset` = 1 and sw 32'h5 @0x40 in the same cycle -> 0x40 reads 0 afterwards.

Source files
------------

// File: rtl/data_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_if
//  Description : M-stage data-memory bus between the EX/M register and memory.
//  Revision    : 1.0
// ============================================================================
interface data_mem_if;
    logic        MemWriteM;
    logic        MemReadM;
    logic [1:0]  st_typeM;
    logic [2:0]  ext_sh_M;
    logic [31:0] ALU_outM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic [3:0]  be_M;
    logic        AdELM;
    logic        AdESM;

    modport master (
        output MemWriteM, MemReadM, st_typeM, ext_sh_M, ALU_outM, WriteDataM,
        input  ReadDataM, be_M, AdELM, AdESM
    );

    modport slave (
        input  MemWriteM, MemReadM, st_typeM, ext_sh_M, ALU_outM, WriteDataM,
        output ReadDataM, be_M, AdELM, AdESM
    );
endinterface
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem
//  Description : MIPS M-stage data memory: byte-enabled stores, async word read,
//                address-exception flags for CP0.
//  Revision    : 1.0
// ============================================================================
module data_mem #(
    parameter int          ADDR_W = 10,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  wire logic   clk,
    input  wire logic   reset,
    data_mem_if.slave   bus
);
    localparam logic [1:0] c_ST_SW  = 2'b00;
    localparam logic [1:0] c_ST_SH  = 2'b01;
    localparam logic [1:0] c_ST_SB  = 2'b10;
    localparam logic [2:0] c_LD_LBU = 3'b001;
    localparam logic [2:0] c_LD_LB  = 3'b010;
    localparam logic [2:0] c_LD_LHU = 3'b011;
    localparam logic [2:0] c_LD_LH  = 3'b100;

    logic [31:0]       r_mem [2**ADDR_W];

    logic [31:0]       w_off;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_idx;
    logic              w_st_valid;
    logic              w_st_misal;
    logic              w_ld_misal;
    logic [3:0]        w_be_raw;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_ades;

    // Below-base addresses wrap to huge offsets and fall out of range.
    assign w_off      = bus.ALU_outM - BASE;
    assign w_in_range = (w_off >> (ADDR_W + 2)) == 32'd0;
    assign w_idx      = w_off[ADDR_W+1:2];

    always_comb begin
        w_st_valid = 1'b1;
        w_st_misal = 1'b0;
        w_be_raw   = 4'b0000;
        w_wdata    = bus.WriteDataM;
        case (bus.st_typeM)
            c_ST_SW: begin
                w_st_misal = |bus.ALU_outM[1:0];
                w_be_raw   = 4'b1111;
            end
            c_ST_SH: begin
                w_st_misal = bus.ALU_outM[0];
                w_be_raw   = bus.ALU_outM[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{bus.WriteDataM[15:0]}};
            end
            c_ST_SB: begin
                w_be_raw   = 4'b0001 << bus.ALU_outM[1:0];
                w_wdata    = {4{bus.WriteDataM[7:0]}};
            end
            default: w_st_valid = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.ext_sh_M)
            c_LD_LBU, c_LD_LB: w_ld_misal = 1'b0;
            c_LD_LHU, c_LD_LH: w_ld_misal = bus.ALU_outM[0];
            default:           w_ld_misal = |bus.ALU_outM[1:0];
        endcase
    end

    assign w_ades = bus.MemWriteM & w_st_valid & (w_st_misal | ~w_in_range);
    assign w_be   = (bus.MemWriteM & w_st_valid & ~w_ades) ? w_be_raw : 4'b0000;

    assign bus.AdESM     = w_ades;
    assign bus.AdELM     = bus.MemReadM & (w_ld_misal | ~w_in_range);
    assign bus.be_M      = w_be;
    assign bus.ReadDataM = w_in_range ? r_mem[w_idx] : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end
endmodule
`default_nettype wire
